// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Initiator side of the ALU start/done handshake. Accepts one
//               command at a time, drives registered operands plus a single
//               start pulse, waits for done (with a timeout guard) and
//               returns the captured result over a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_a,
  input  logic [31:0]       cmd_b,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_cin,
  input  logic              cmd_bin,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [1:0]        alu_op_sel,
  output logic              alu_cin,
  output logic              alu_bin,
  output logic              alu_start,
  input  logic [63:0]       alu_result,
  input  logic              alu_carry_out,
  input  logic              alu_borrow_out,
  input  logic [5:0]        alu_comp_result,
  input  logic              alu_overflow,
  input  logic              alu_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_result,
  output logic [8:0]        rsp_flags,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic [7:0]        timeout_count
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  // The counter holds the number of WAIT cycles already elapsed. Firing when it
  // equals TIMEOUT_CYCLES-2 (so it would become TIMEOUT_CYCLES-1 on this edge)
  // places rsp_valid exactly TIMEOUT_CYCLES cycles after the start pulse.
  localparam logic [WAIT_W-1:0] c_wait_fire = WAIT_W'(TIMEOUT_CYCLES - 2);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_cmd_fire;
  logic              w_rsp_fire;
  logic              w_in_wait;
  logic              w_done_hit;
  logic              w_timeout_hit;

  assign w_cmd_fire    = cmd_valid && (r_state == c_st_idle);
  assign w_rsp_fire    = rsp_ready && (r_state == c_st_resp);
  assign w_in_wait     = (r_state == c_st_wait);
  // done has priority over a coincident timeout
  assign w_done_hit    = w_in_wait && alu_done;
  assign w_timeout_hit = w_in_wait && !alu_done && (r_wait_cnt == c_wait_fire);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:  if (w_cmd_fire) w_state_next = c_st_issue;
      c_st_issue: w_state_next = c_st_wait;
      c_st_wait:  if (w_done_hit || w_timeout_hit) w_state_next = c_st_resp;
      c_st_resp:  if (w_rsp_fire) w_state_next = c_st_idle;
      default:    w_state_next = c_st_idle;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    cmd_ready = (r_state == c_st_idle);
    alu_start = (r_state == c_st_issue);
    rsp_valid = (r_state == c_st_resp);
    busy      = (r_state != c_st_idle);
  end

  // Operand registers: change only when a command is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op_sel <= '0;
      alu_cin    <= 1'b0;
      alu_bin    <= 1'b0;
    end else if (w_cmd_fire) begin
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
      alu_op_sel <= cmd_op;
      alu_cin    <= cmd_cin;
      alu_bin    <= cmd_bin;
    end
  end

  // Wait counter: cleared while issuing, advanced every WAIT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_wait_cnt <= '0;
    else if (r_state == c_st_issue) r_wait_cnt <= '0;
    else if (w_in_wait)           r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
  end

  // Response capture: held untouched while RESP waits for the handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
    end else if (w_done_hit) begin
      rsp_result  <= alu_result;
      rsp_flags   <= {alu_overflow, alu_borrow_out, alu_carry_out, alu_comp_result};
      rsp_timeout <= 1'b0;
    end else if (w_timeout_hit) begin
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b1;
    end
  end

  // Activity counters: completions wrap, timeouts saturate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count      <= '0;
      timeout_count <= '0;
    end else begin
      if (w_done_hit) op_count <= op_count + CNT_W'(1);
      if (w_timeout_hit && (timeout_count != 8'hFF)) timeout_count <= timeout_count + 8'd1;
    end
  end

endmodule
`default_nettype wire
